// File: rtl/uart_rx_if.sv
// uart_rx_if: register-block side of the UART receiver.
//
// Groups the receive FIFO read port, FIFO status, and the sticky error flags.
//   fifo_rd_en      master -> slave  pop one character (ignored when empty)
//   fifo_rd_data    slave  -> master character popped by the previous fifo_rd_en
//   fifo_clear      master -> slave  single-cycle FIFO flush
//   fifo_full       slave  -> master FIFO holds its full depth
//   fifo_empty      slave  -> master FIFO holds nothing
//   err_clear       master -> slave  clears all sticky error flags
//   overflow_error  slave  -> master a character was dropped on a full FIFO
//   parity_error    slave  -> master a parity mismatch was received
//   frame_error     slave  -> master a stop bit was sampled low
//
// Handshake: the read side is a pop/valid-next-cycle port. fifo_empty low is
// the "valid" indication; a cycle with fifo_rd_en high while fifo_empty is low
// is a completed pop, and fifo_rd_data holds that character from the next clk
// onward until the next completed pop. fifo_rd_en while empty is ignored.
interface uart_rx_if;
   logic       fifo_rd_en;
   logic [7:0] fifo_rd_data;
   logic       fifo_clear;
   logic       fifo_full;
   logic       fifo_empty;
   logic       err_clear;
   logic       overflow_error;
   logic       parity_error;
   logic       frame_error;

   modport master (
      output fifo_rd_en, fifo_clear, err_clear,
      input  fifo_rd_data, fifo_full, fifo_empty,
      input  overflow_error, parity_error, frame_error
   );

   modport slave (
      input  fifo_rd_en, fifo_clear, err_clear,
      output fifo_rd_data, fifo_full, fifo_empty,
      output overflow_error, parity_error, frame_error
   );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: receive half of the UART.
//
// Deserialises the asynchronous serial line using a shared 16x oversampling
// strobe, checks parity and stop bits, and pushes characters into an internal
// synchronous FIFO drained through the bus interface.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   parity       1 = even parity bit present
//   data_bits    data bits = 5 + value
//   stop_bits    0 = one stop bit, 1 = two stop bits
//   rx_strb      one-clk pulse at 16x baud
//   rx_strb_en   requests the strobe; generator restarts its divider on the rise
//   rx_line      serial line, asynchronous, idle high
//   dbg_state    current FSM state (debug)
//   bus          FIFO read port, FIFO status, sticky error flags (slave side)
module uart_rx #(
   parameter int FIFO_DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       parity,
   input  logic [1:0] data_bits,
   input  logic       stop_bits,
   input  logic       rx_strb,
   output logic       rx_strb_en,
   input  logic       rx_line,
   output logic [2:0] dbg_state,
   uart_rx_if.slave   bus
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP0  = 3'd4,
      STOP1  = 3'd5
   } state_t;

   // ---------------------------------------------------------------- sync
   logic rx_meta, rx_s, rx_prev;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx_line;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   logic fall;
   assign fall = rx_prev & ~rx_s;

   // ----------------------------------------------------------------- fsm
   state_t     state;
   logic [3:0] smp_cnt;
   logic [3:0] cnt_next;
   logic       s6, s7;
   logic       decision;
   logic [7:0] shift_reg;
   logic [2:0] bit_cnt;
   logic [2:0] last_bit;
   logic       run_par;
   logic       cfg_parity;
   logic [1:0] cfg_data_bits;
   logic       cfg_stop_bits;
   logic       par_pend;
   logic       frm_pend;
   logic       push_req;
   logic       strb_en;
   logic [7:0] char_rj;

   // Sample points are named by the counter value reached at that strobe, so
   // the start bit is validated on the 8th strobe after enable.
   assign cnt_next = smp_cnt + 4'd1;
   assign decision = (s6 & s7) | (s6 & rx_s) | (s7 & rx_s);
   assign last_bit = {1'b0, cfg_data_bits} + 3'd4;
   // Bits arrive LSB first into the MSB end; shorter characters sit high.
   assign char_rj  = shift_reg >> (2'd3 - cfg_data_bits);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         strb_en       <= 1'b0;
         smp_cnt       <= 4'd0;
         s6            <= 1'b1;
         s7            <= 1'b1;
         shift_reg     <= 8'd0;
         bit_cnt       <= 3'd0;
         run_par       <= 1'b0;
         cfg_parity    <= 1'b0;
         cfg_data_bits <= 2'd0;
         cfg_stop_bits <= 1'b0;
         par_pend      <= 1'b0;
         frm_pend      <= 1'b0;
         push_req      <= 1'b0;
      end else begin
         push_req <= 1'b0;
         case (state)
            IDLE: begin
               strb_en <= 1'b0;
               if (fall) begin
                  cfg_parity    <= parity;
                  cfg_data_bits <= data_bits;
                  cfg_stop_bits <= stop_bits;
                  smp_cnt       <= 4'd0;
                  shift_reg     <= 8'd0;
                  bit_cnt       <= 3'd0;
                  run_par       <= 1'b0;
                  par_pend      <= 1'b0;
                  frm_pend      <= 1'b0;
                  strb_en       <= 1'b1;
                  state         <= START;
               end
            end
            default: begin
               if (rx_strb) begin
                  smp_cnt <= cnt_next;
                  if (cnt_next == 4'd6) s6 <= rx_s;
                  if (cnt_next == 4'd7) s7 <= rx_s;
                  if (cnt_next == 4'd8) begin
                     case (state)
                        START: begin
                           if (!decision) begin
                              state <= DATA;
                           end else begin
                              // High at mid start bit: a glitch, not a frame.
                              state   <= IDLE;
                              strb_en <= 1'b0;
                           end
                        end
                        DATA: begin
                           shift_reg <= {decision, shift_reg[7:1]};
                           run_par   <= run_par ^ decision;
                           bit_cnt   <= bit_cnt + 3'd1;
                           if (bit_cnt == last_bit)
                              state <= cfg_parity ? PARITY : STOP0;
                        end
                        PARITY: begin
                           if (decision != run_par) par_pend <= 1'b1;
                           state <= STOP0;
                        end
                        STOP0: begin
                           if (!decision) frm_pend <= 1'b1;
                           if (cfg_stop_bits) begin
                              state <= STOP1;
                           end else begin
                              state    <= IDLE;
                              strb_en  <= 1'b0;
                              push_req <= 1'b1;
                           end
                        end
                        STOP1: begin
                           if (!decision) frm_pend <= 1'b1;
                           state    <= IDLE;
                           strb_en  <= 1'b0;
                           push_req <= 1'b1;
                        end
                        default: begin
                           state   <= IDLE;
                           strb_en <= 1'b0;
                        end
                     endcase
                  end
               end
            end
         endcase
      end
   end

   assign rx_strb_en = strb_en;
   assign dbg_state  = state;

   // ---------------------------------------------------------------- fifo
   // char_rj, par_pend and frm_pend stay stable in the push cycle: a new start
   // edge in that same cycle only updates them at its end.
   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic [AW:0] count;
   logic        full, empty;
   logic        do_pop, do_push, ovf_set;
   logic [7:0]  rd_data;
   logic        ovf_err, par_err, frm_err;

   assign count = wr_ptr - rd_ptr;
   assign full  = (count == (AW+1)'(FIFO_DEPTH));
   assign empty = (count == '0);

   // Pop is taken first, so a push on a full FIFO with a pop succeeds.
   assign do_pop  = bus.fifo_rd_en & ~empty & ~bus.fifo_clear;
   assign do_push = push_req & ~bus.fifo_clear & (~full | do_pop);
   assign ovf_set = push_req & ~bus.fifo_clear & full & ~do_pop;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         rd_data <= 8'd0;
      end else if (bus.fifo_clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_pop) begin
            rd_data <= mem[rd_ptr[AW-1:0]];
            rd_ptr  <= rd_ptr + 1'b1;
         end
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= char_rj;
   end

   // Sticky flags: a set in the same cycle as err_clear wins.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_err <= 1'b0;
         par_err <= 1'b0;
         frm_err <= 1'b0;
      end else begin
         ovf_err <= (ovf_err & ~bus.err_clear) | ovf_set;
         par_err <= (par_err & ~bus.err_clear) | (push_req & par_pend);
         frm_err <= (frm_err & ~bus.err_clear) | (push_req & frm_pend);
      end
   end

   assign bus.fifo_rd_data   = rd_data;
   assign bus.fifo_full      = full;
   assign bus.fifo_empty     = empty;
   assign bus.overflow_error = ovf_err;
   assign bus.parity_error   = par_err;
   assign bus.frame_error    = frm_err;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed testbench for uart_rx.
//
// A local baud model produces one strobe every 16 clk while rx_strb_en is
// high; the serial line is driven with 16 strobes (256 clk) per bit.
module tb_uart_rx;

   localparam int DEPTH   = 4;
   localparam int BIT_CLK = 256;

   logic       clk;
   logic       rst_n;
   logic       cfg_parity;
   logic [1:0] cfg_data_bits;
   logic       cfg_stop_bits;
   logic       rx_strb;
   logic       rx_strb_en;
   logic       rx_line;
   logic [2:0] dbg_state;

   uart_rx_if bus ();

   uart_rx #(.FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .parity     (cfg_parity),
      .data_bits  (cfg_data_bits),
      .stop_bits  (cfg_stop_bits),
      .rx_strb    (rx_strb),
      .rx_strb_en (rx_strb_en),
      .rx_line    (rx_line),
      .dbg_state  (dbg_state),
      .bus        (bus)
   );

   // ------------------------------------------------ clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Baud model: divider restarts while disabled, strobe every 16 clk.
   logic [3:0] div;
   always @(negedge clk) begin
      if (!rx_strb_en) begin
         div     = 4'd0;
         rx_strb = 1'b0;
      end else begin
         rx_strb = (div == 4'd15);
         div     = div + 4'd1;
      end
   end

   // --------------------------------------------------------- scoreboard
   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ------------------------------------------------------ driver tasks
   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] data, input int nbits,
                             input bit par_en, input bit par_flip,
                             input bit two_stop, input bit stop_low);
      logic p;
      p = 1'b0;
      rx_line = 1'b0;
      wait_clk(BIT_CLK);
      for (int i = 0; i < nbits; i++) begin
         rx_line = data[i];
         p = p ^ data[i];
         wait_clk(BIT_CLK);
      end
      if (par_en) begin
         rx_line = p ^ par_flip;
         wait_clk(BIT_CLK);
      end
      rx_line = ~stop_low;
      wait_clk(BIT_CLK);
      if (two_stop) wait_clk(BIT_CLK);
      if (!stop_low) wait_clk(32);
   endtask

   task automatic pop_check(input string tag);
      logic [7:0] exp;
      exp = exp_q.pop_front();
      bus.fifo_rd_en = 1'b1;
      wait_clk(1);
      bus.fifo_rd_en = 1'b0;
      check(tag, bus.fifo_rd_data, exp);
   endtask

   task automatic clear_errors();
      bus.err_clear = 1'b1;
      wait_clk(1);
      bus.err_clear = 1'b0;
      wait_clk(1);
   endtask

   task automatic check_err_flags(input string tag, input logic [2:0] exp);
      check(tag, {bus.overflow_error, bus.parity_error, bus.frame_error}, exp);
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      rst_n          = 1'b0;
      rx_line        = 1'b1;
      cfg_parity     = 1'b0;
      cfg_data_bits  = 2'd3;
      cfg_stop_bits  = 1'b0;
      bus.fifo_rd_en = 1'b0;
      bus.fifo_clear = 1'b0;
      bus.err_clear  = 1'b0;
      wait_clk(4);

      check("reset_strb_en", rx_strb_en, 0);
      check("reset_empty", bus.fifo_empty, 1);
      check("reset_full", bus.fifo_full, 0);
      check("reset_rd_data", bus.fifo_rd_data, 8'h00);
      check_err_flags("reset_errors", 3'b000);
      check("reset_state", dbg_state, 3'd0);
      rst_n = 1'b1;
      wait_clk(4);

      // 8N1 0xA5
      send_frame(8'hA5, 8, 0, 0, 0, 0);
      exp_q.push_back(8'hA5);
      check("a5_not_empty", bus.fifo_empty, 0);
      pop_check("a5_data");
      check("a5_empty_after", bus.fifo_empty, 1);
      check_err_flags("a5_errors", 3'b000);

      // 5E2 0x15, good parity then flipped parity
      cfg_parity    = 1'b1;
      cfg_data_bits = 2'd0;
      cfg_stop_bits = 1'b1;
      send_frame(8'h15, 5, 1, 0, 1, 0);
      exp_q.push_back(8'h15);
      pop_check("5e2_good_data");
      check_err_flags("5e2_good_errors", 3'b000);
      send_frame(8'h15, 5, 1, 1, 1, 0);
      exp_q.push_back(8'h15);
      pop_check("5e2_bad_data");
      check_err_flags("5e2_bad_parity_flag", 3'b010);
      wait_clk(300);
      check("5e2_parity_sticky", bus.parity_error, 1);
      clear_errors();
      check_err_flags("5e2_after_clear", 3'b000);

      // Low glitch of 4 strobes on an idle line
      cfg_parity    = 1'b0;
      cfg_data_bits = 2'd3;
      cfg_stop_bits = 1'b0;
      rx_line = 1'b0;
      wait_clk(20);
      check("glitch_strb_en_up", rx_strb_en, 1);
      wait_clk(44);
      rx_line = 1'b1;
      wait_clk(BIT_CLK);
      check("glitch_state_idle", dbg_state, 3'd0);
      check("glitch_strb_en_down", rx_strb_en, 0);
      check("glitch_no_push", bus.fifo_empty, 1);
      check_err_flags("glitch_errors", 3'b000);

      // 8N1 0x3C with low stop bit, then line held low
      send_frame(8'h3C, 8, 0, 0, 0, 1);
      exp_q.push_back(8'h3C);
      wait_clk(3000);
      check("frame_err_flag", bus.frame_error, 1);
      check("frame_err_strb_en", rx_strb_en, 0);
      pop_check("frame_err_data");
      check("frame_err_single_push", bus.fifo_empty, 1);
      rx_line = 1'b1;
      wait_clk(64);
      clear_errors();
      check_err_flags("frame_after_clear", 3'b000);

      // DEPTH + 1 frames without reads
      for (int i = 0; i <= DEPTH; i++) begin
         send_frame(8'h40 + 8'(i), 8, 0, 0, 0, 0);
         if (i < DEPTH) exp_q.push_back(8'h40 + 8'(i));
         if (i == DEPTH - 1) begin
            check("ovf_full_at_depth", bus.fifo_full, 1);
            check("ovf_none_yet", bus.overflow_error, 0);
         end
      end
      check("ovf_full", bus.fifo_full, 1);
      check("ovf_flag", bus.overflow_error, 1);
      for (int i = 0; i < DEPTH; i++) pop_check("ovf_drain");
      check("ovf_drained_empty", bus.fifo_empty, 1);
      clear_errors();
      check_err_flags("ovf_after_clear", 3'b000);

      // Reset during the data bits of 0xFF with a character already queued
      send_frame(8'h5A, 8, 0, 0, 0, 0);
      check("rst_prefill", bus.fifo_empty, 0);
      fork
         send_frame(8'hFF, 8, 0, 0, 0, 0);
         begin
            wait_clk(BIT_CLK * 3 + 50);
            check("rst_mid_frame_busy", rx_strb_en, 1);
            rst_n = 1'b0;
            wait_clk(3);
            check("rst_strb_en", rx_strb_en, 0);
            check("rst_empty", bus.fifo_empty, 1);
            check("rst_full", bus.fifo_full, 0);
            check("rst_rd_data", bus.fifo_rd_data, 8'h00);
            check_err_flags("rst_errors", 3'b000);
            check("rst_state", dbg_state, 3'd0);
            rst_n = 1'b1;
         end
      join
      send_frame(8'h81, 8, 0, 0, 0, 0);
      exp_q.push_back(8'h81);
      pop_check("rst_after_data");
      check("rst_after_empty", bus.fifo_empty, 1);
      check_err_flags("rst_after_errors", 3'b000);

      // ---------------------------------------------------------- report
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the AXI4-Lite UART. Deserialises the asynchronous line `i_uart_rx` (which carries frames produced by a peer transmitter, or by our own `o_uart_tx` in loopback) using a shared 16x-oversampling strobe, and checks parity and stop bits. Received characters are pushed into an internal synchronous FIFO that the register block drains. Frame configuration uses the same encoding as the transmit path, so one configuration register drives both directions.

## Interface
- `FIFO_DEPTH`, 16, receive FIFO depth in characters (power of two, ≥2)
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `i_parity`  in  1  1 = even parity bit present
- `i_data_bits`  in  2  data bits = 5 + value (0→5 … 3→8)
- `i_stop_bits`  in  1  0 = one stop bit, 1 = two stop bits
- `i_fifo_rd_en`  in  1  pop one character; ignored when empty
- `o_fifo_rd_data`  out  8  popped character, right-justified, unused MSBs zero
- `i_fifo_clear`  in  1  flush FIFO (single-cycle pulse)
- `o_fifo_full`  out  1  FIFO full
- `o_fifo_empty`  out  1  FIFO empty
- `i_err_clear`  in  1  clears all sticky error flags
- `o_overflow_error`  out  1  sticky; a character was dropped because the FIFO was full
- `o_parity_error`  out  1  sticky; a parity mismatch was received
- `o_frame_error`  out  1  sticky; a stop bit was sampled low
- `i_rx_strb`  in  1  one-clk pulse at 16x baud from the baud generator
- `o_rx_strb_en`  out  1  requests the strobe; the generator restarts its divider on the rising edge
- `i_uart_rx`  in  1  serial line, asynchronous, idle high

## Operation
- `i_uart_rx` passes through a 2-FF synchroniser (reset to 1), giving `rx_s`. All logic uses `rx_s`.
- Oversampling counter `smp_cnt` (4 bits) increments on each `i_rx_strb` and wraps 15→0. Each wrap marks one bit period.
- Bit decision: majority of `rx_s` at strobes with `smp_cnt` = 6, 7 and 8, evaluated at the `smp_cnt` = 8 strobe.
- States: IDLE, START, DATA, PARITY, STOP0, STOP1.
- IDLE:
  - `o_rx_strb_en` = 0.
  - On a falling edge of `rx_s` (previous 1, current 0), latch `i_parity`, `i_data_bits`, `i_stop_bits`.
  - Clear `smp_cnt`, the shift register, the bit count and the running parity, then go to START.
- START:
  - Decision 0 → DATA with `smp_cnt` continuing.
  - Decision 1 → treated as a glitch: return to IDLE with no error and no write.
- DATA:
  - Shift in LSB first at each decision and XOR into the running parity.
  - After the (5 + `data_bits`)th bit, go to PARITY if parity is enabled, else STOP0.
- PARITY: the received bit ≠ running XOR of the data bits (even parity) → set the pending parity flag. Then go to STOP0.
- STOP0:
  - Decision 0 → pending frame error.
  - Two stop bits → STOP1.
  - One stop bit → complete the frame.
- STOP1: decision 0 → pending frame error; complete the frame.
- Frame completion:
  - Return to IDLE at the mid-stop decision, so a back-to-back start edge is caught.
  - Push the right-justified character to the FIFO; this happens even with a parity or frame error.
  - If the FIFO is full, drop the character and set `o_overflow_error`.
  - Pending parity and frame flags OR into their sticky outputs.
- A line stuck low after a frame error does not retrigger; IDLE needs a fresh high→low edge.
- `i_err_clear` in the same cycle as an error set: the set wins.
- `i_fifo_clear` and `i_fifo_rd_en` do not affect the FSM. A push coincident with `i_fifo_clear` is discarded.

## Timing
- Reset values:
  - `o_rx_strb_en` = 0, `o_fifo_empty` = 1, `o_fifo_full` = 0, `o_fifo_rd_data` = 0.
  - All three error flags = 0; state = IDLE.
- Edge-detect latency: 2 clk of synchroniser, then 1 clk to START. `o_rx_strb_en` rises in the clk after the edge is registered.
- Start validation is 8 strobes after enable (≈ mid start bit). Each following bit decision is 16 strobes later.
- FIFO push is asserted in the clk after the final stop decision. `o_fifo_empty` falls 1 clk after the push.
- Read: `o_fifo_rd_data` is valid in the clk after `i_fifo_rd_en` (registered output).
- Simultaneous push and pop on a full FIFO: the pop is taken first, the push succeeds and there is no overflow.
- Reset mid-frame: the FSM returns to IDLE, the partial character is discarded, and the FIFO is emptied.

## Test plan
- 8N1, line sends 0xA5 at 16 clk per strobe → one push; read returns 0xA5; all error flags 0.
- 5E2 (`i_data_bits`=0, parity=1, stop=1), character 0x15 with correct parity bit 1 → read 0x15. Repeat with the parity bit flipped → 0x15 pushed and `o_parity_error` = 1 until `i_err_clear`.
- Low glitch of 4 strobes on an idle line → no push, no error, FSM back in IDLE, `o_rx_strb_en` drops.
- 8N1 0x3C with the stop bit driven low → 0x3C pushed and `o_frame_error` = 1. The line then held low → no further frames.
- `FIFO_DEPTH` + 1 frames without reads → `o_fifo_full` = 1 and `o_overflow_error` = 1. Draining returns the first `FIFO_DEPTH` characters in order.
- `rst_n` asserted during the data bits of 0xFF, then 0x81 sent → only 0x81 is read; all outputs are at reset values during reset.
